dmem_dump_reader: RTL and testbench

- Read-only initiator on the data-memory read port. On a start pulse it walks a word-address range and reads each 32-bit word.
- Each word is serialized as 4 bytes, MSB first, onto a valid/ready byte stream feeding the debug UART transmitter.
- It lets the debug unit dump data memory to the host after a program halts. It never writes memory.

---
 rtl/dmem_dump_reader.sv | 103 ++++++++++
 tb/tb_dmem_dump_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_reader.sv
// Data-memory dump reader: walks an inclusive word-address range, reads each
// word through the data-memory read port and serializes it MSB-first as a
// valid/ready byte stream for the debug UART transmitter. Never writes memory.
module dmem_dump_reader #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 7,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [NB_ADDR-1:0] addr_first_i,
  input  logic [NB_ADDR-1:0] addr_last_i,
  output logic [NB_ADDR-1:0] mem_addr_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  input  logic [NB_DATA-1:0] mem_data_i,
  output logic [NB_BYTE-1:0] tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned NumBytes = NB_DATA / NB_BYTE;
  localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [CntW-1:0] LastByte = CntW'(NumBytes - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StSend,
    StDone
  } state_e;

  state_e              state_q;
  logic [NB_ADDR-1:0]  addr_q;
  logic [NB_ADDR-1:0]  last_q;
  logic [CntW-1:0]     byte_cnt_q;
  logic [NB_DATA-1:0]  word_q;

  // Dump sequencer: range capture, one-cycle read request, byte shift-out.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      last_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            addr_q  <= addr_first_i;
            last_q  <= addr_last_i;
            // An inverted range finishes without touching memory.
            state_q <= (addr_first_i > addr_last_i) ? StDone : StReq;
          end
        end
        StReq: begin
          // Memory has updated mem_data_i on the mid-cycle negedge.
          word_q     <= mem_data_i;
          byte_cnt_q <= '0;
          state_q    <= StSend;
        end
        StSend: begin
          if (tx_ready_i) begin
            word_q     <= word_q << NB_BYTE;
            byte_cnt_q <= byte_cnt_q + CntW'(1);
            if (byte_cnt_q == LastByte) begin
              // Compare before incrementing so the top address never wraps.
              if (addr_q == last_q) begin
                state_q <= StDone;
              end else begin
                addr_q  <= addr_q + NB_ADDR'(1);
                state_q <= StReq;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decode only from registered state, so they are glitch-free and
  // hold steady while the transmitter stalls.
  always_comb begin
    mem_read_o  = (state_q == StReq);
    mem_addr_o  = ((state_q == StReq) || (state_q == StSend)) ? addr_q : '0;
    tx_valid_o  = (state_q == StSend);
    tx_data_o   = (state_q == StSend) ? word_q[NB_DATA-1 -: NB_BYTE] : '0;
    busy_o      = (state_q == StReq) || (state_q == StSend);
    done_o      = (state_q == StDone);
    mem_write_o = 1'b0;
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Self-checking bench for dmem_dump_reader: table of directed ranges, hand
// sequences for backpressure / reset / start-while-busy, and random ranges
// with random backpressure, all checked against a byte-stream model.
module tb_dmem_dump_reader;

  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_ADDR = 7;
  localparam int unsigned NB_BYTE = 8;
  localparam int Budget = 5000;

  logic               clk_i = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic [NB_ADDR-1:0] addr_first_i = '0;
  logic [NB_ADDR-1:0] addr_last_i = '0;
  logic [NB_ADDR-1:0] mem_addr_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic [NB_DATA-1:0] mem_data_i = '0;
  logic [NB_BYTE-1:0] tx_data_o;
  logic               tx_valid_o;
  logic               tx_ready_i = 1'b0;
  logic               busy_o;
  logic               done_o;

  logic [NB_DATA-1:0] mem [128];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NB_ADDR-1:0] first;
    logic [NB_ADDR-1:0] last;
    int                 exp_bytes;
    int                 exp_done;
  } vec_t;

  vec_t vecs [7];

  dmem_dump_reader #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR),
    .NB_BYTE(NB_BYTE)
  ) dut (
    .clock_i     (clk_i),
    .reset_i     (rst_n),
    .start_i     (start_i),
    .addr_first_i(addr_first_i),
    .addr_last_i (addr_last_i),
    .mem_addr_o  (mem_addr_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_data_i  (mem_data_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Data memory: registered read data updated on negedge while read is strobed.
  always @(negedge clk_i) begin
    if (mem_read_o) mem_data_i <= mem[mem_addr_o];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one dump. mode 0: ready always 1; 1: random ready; 2: ready pattern
  // 1,0,0,1,0,1,1 over valid cycles then 1. inject pulses start mid-SEND.
  task automatic run_dump(input logic [NB_ADDR-1:0] f, input logic [NB_ADDR-1:0] l,
                          input int mode, input bit inject,
                          output int ndone, output int nbytes);
    logic [NB_BYTE-1:0] acc [$];
    logic [NB_BYTE-1:0] exp_q [$];
    logic               pat [7];
    logic [NB_BYTE-1:0] prev_data;
    logic [NB_ADDR-1:0] ea;
    logic [NB_DATA-1:0] w;
    bit   prev_hold, rd_err, hold_err, busy_err, wr_err, injected, r;
    int   reads, pat_idx, nwords, bad;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    prev_hold = 0; rd_err = 0; hold_err = 0; busy_err = 0; wr_err = 0; injected = 0;
    reads = 0; pat_idx = 0; prev_data = '0; ndone = 0;
    // Reference stream: every word in the range, MSB byte first.
    nwords = (f <= l) ? (int'(l) - int'(f) + 1) : 0;
    for (int a = int'(f); a <= int'(l); a++) begin
      w = mem[a];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end

    @(negedge clk_i);
    addr_first_i = f;
    addr_last_i  = l;
    start_i      = 1'b1;
    tx_ready_i   = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int n = 1; n <= Budget; n++) begin
      if (mem_write_o !== 1'b0) wr_err = 1;
      if (prev_hold && (!tx_valid_o || tx_data_o !== prev_data)) hold_err = 1;
      if (mem_read_o) begin
        ea = f + NB_ADDR'(reads);
        if (mem_addr_o !== ea) rd_err = 1;
        reads++;
      end
      if (done_o) begin
        if (busy_o || tx_valid_o || mem_read_o) busy_err = 1;
        ndone = n;
        break;
      end
      if (!busy_o) busy_err = 1;
      start_i = 1'b0;
      if (inject && !injected && tx_valid_o) begin
        start_i      = 1'b1;
        addr_first_i = f ^ 7'h2A;
        addr_last_i  = l ^ 7'h15;
        injected     = 1;
      end
      case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = 1'b0;
          if (tx_valid_o) begin
            r = (pat_idx < 7) ? pat[pat_idx] : 1'b1;
            pat_idx++;
          end
        end
      endcase
      tx_ready_i = r;
      if (tx_valid_o && r) acc.push_back(tx_data_o);
      prev_hold = tx_valid_o && !r;
      prev_data = tx_data_o;
      @(negedge clk_i);
    end
    tx_ready_i = 1'b0;
    start_i    = 1'b0;
    nbytes     = acc.size();

    if (ndone == 0) chk("done_timeout", 0, 1);
    chk("stream_len", 64'(acc.size()), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < acc.size() && i < exp_q.size(); i++) begin
      if (acc[i] !== exp_q[i]) bad++;
    end
    chk("stream_data_mismatches", 64'(bad), 0);
    chk("read_count", 64'(reads), 64'(nwords));
    chk("read_addr_err", 64'(rd_err), 0);
    chk("hold_err", 64'(hold_err), 0);
    chk("busy_err", 64'(busy_err), 0);
    chk("write_err", 64'(wr_err), 0);
    @(negedge clk_i);
    chk("idle_after_done", {done_o, busy_o, tx_valid_o, mem_read_o, mem_addr_o}, 0);
  endtask

  initial begin
    int ndone, nbytes, seen_bad;
    logic [NB_ADDR-1:0] f, l;

    vecs[0] = '{first: 7'd0,   last: 7'd127, exp_bytes: 512, exp_done: 641};
    vecs[1] = '{first: 7'd5,   last: 7'd5,   exp_bytes: 4,   exp_done: 6};
    vecs[2] = '{first: 7'd10,  last: 7'd4,   exp_bytes: 0,   exp_done: 1};
    vecs[3] = '{first: 7'd127, last: 7'd127, exp_bytes: 4,   exp_done: 6};
    vecs[4] = '{first: 7'd126, last: 7'd127, exp_bytes: 8,   exp_done: 11};
    vecs[5] = '{first: 7'd0,   last: 7'd0,   exp_bytes: 4,   exp_done: 6};
    vecs[6] = '{first: 7'd100, last: 7'd99,  exp_bytes: 0,   exp_done: 1};

    for (int i = 0; i < 128; i++) mem[i] = 32'(i) * 32'h0101_0101;

    // Reset state.
    repeat (2) @(negedge clk_i);
    chk("reset_outputs", {mem_addr_o, mem_read_o, mem_write_o, tx_data_o, tx_valid_o,
                          busy_o, done_o}, 0);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("idle_outputs", {mem_addr_o, mem_read_o, mem_write_o, tx_data_o, tx_valid_o,
                         busy_o, done_o}, 0);

    // Directed ranges with ready held high.
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        mem[5] = 32'hDEAD_BEEF;
        mem[3] = 32'h1122_3344;
      end
      run_dump(vecs[i].first, vecs[i].last, 0, 1'b0, ndone, nbytes);
      chk($sformatf("vec%0d_bytes", i), 64'(nbytes), 64'(vecs[i].exp_bytes));
      chk($sformatf("vec%0d_done_latency", i), 64'(ndone), 64'(vecs[i].exp_done));
    end

    // Backpressure: 1 REQ + 7 SEND cycles to move 4 bytes, then DONE.
    run_dump(7'd3, 7'd3, 2, 1'b0, ndone, nbytes);
    chk("bp_bytes", 64'(nbytes), 4);
    chk("bp_done_latency", 64'(ndone), 9);

    // Start while busy is ignored; original range completes.
    run_dump(7'd20, 7'd22, 0, 1'b1, ndone, nbytes);
    chk("busy_start_bytes", 64'(nbytes), 12);
    chk("busy_start_done", 64'(ndone), 16);

    // Asynchronous reset in the middle of SEND.
    @(negedge clk_i);
    addr_first_i = 7'd0; addr_last_i = 7'd127; start_i = 1'b1; tx_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("pre_reset_in_send", 64'(tx_valid_o), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {mem_addr_o, mem_read_o, mem_write_o, tx_data_o,
                                   tx_valid_o, busy_o, done_o}, 0);
    tx_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    seen_bad = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (done_o || busy_o || tx_valid_o || mem_read_o) seen_bad++;
    end
    chk("post_reset_quiet", 64'(seen_bad), 0);
    run_dump(7'd5, 7'd5, 0, 1'b0, ndone, nbytes);
    chk("post_reset_dump_done", 64'(ndone), 6);

    // Random contents, ranges and backpressure.
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    for (int k = 0; k < 25; k++) begin
      f = NB_ADDR'($urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) begin
        l = NB_ADDR'($urandom_range(0, 127));
      end else begin
        l = (int'(f) + 5 > 127) ? 7'd127 : f + NB_ADDR'($urandom_range(0, 5));
      end
      run_dump(f, l, 1, 1'($urandom_range(0, 1)), ndone, nbytes);
      chk($sformatf("rand%0d_bytes", k), 64'(nbytes),
          64'((f <= l) ? 4 * (int'(l) - int'(f) + 1) : 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
